// File: rtl/multicycle_alu.sv
// multicycle_alu: clocked ALU with single-cycle ops plus iterative radix-4 Booth MUL
// and non-restoring DIV, sequenced by a start/busy/done handshake.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DFIX, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_a, r_mq, r_dvs, r_quo;
    logic [WIDTH+1:0] r_acc;
    logic [WIDTH:0]   r_rem;
    logic             r_q, r_qneg, r_rneg, r_dz;
    logic             w_accept, w_single;
    logic [SHW-1:0]   w_amt, w_namt;
    logic [WIDTH-1:0] w_lo, w_abs_a, w_abs_b, w_mq_n, w_qn, w_rmag, w_qs, w_rsgn;
    logic [WIDTH+1:0] w_m, w_add, w_sum, w_acc_n;
    logic [WIDTH:0]   w_rs, w_rn;

    assign w_accept = start && r_state == S_IDLE;
    assign w_single = op != OP_MUL && op != OP_DIV;
    assign w_amt    = b[SHW-1:0];
    assign w_namt   = -w_amt;
    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;

    always_comb begin
        w_lo = '0;
        case (op)
            4'b0000: w_lo = a & b;
            4'b0001: w_lo = a | b;
            4'b0010: w_lo = -a;
            4'b0011: w_lo = ~a;
            4'b0100, 4'b1110: w_lo = a + b;
            4'b0101: w_lo = a - b;
            4'b1000: w_lo = a >> w_amt;
            4'b1001: w_lo = $signed(a) >>> w_amt;
            4'b1010: w_lo = a << w_amt;
            4'b1011: w_lo = (a >> w_amt) | (a << w_namt);
            4'b1100: w_lo = (a << w_amt) | (a >> w_namt);
            4'b1101: w_lo = b + WIDTH'(1);
            default: w_lo = '0;
        endcase
    end

    // Booth bit-pair recoding of {mq[1:0], q}; acc carries two guard bits so +/-2M fits
    assign w_m = {{2{r_a[WIDTH-1]}}, r_a};
    always_comb begin
        w_add = '0;
        case ({r_mq[1:0], r_q})
            3'b001, 3'b010: w_add = w_m;
            3'b011:         w_add = w_m << 1;
            3'b100:         w_add = -(w_m << 1);
            3'b101, 3'b110: w_add = -w_m;
            default:        w_add = '0;
        endcase
    end
    assign w_sum   = r_acc + w_add;
    assign w_acc_n = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
    assign w_mq_n  = {w_sum[1:0], r_mq[WIDTH-1:2]};

    // Non-restoring step on magnitudes; the remainder is restored once in DFIX
    assign w_rs   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_rn   = r_rem[WIDTH] ? w_rs + {1'b0, r_dvs} : w_rs - {1'b0, r_dvs};
    assign w_qn   = {r_quo[WIDTH-2:0], ~w_rn[WIDTH]};
    assign w_rmag = r_rem[WIDTH] ? r_rem[WIDTH-1:0] + r_dvs : r_rem[WIDTH-1:0];
    assign w_qs   = r_qneg ? -r_quo : r_quo;
    assign w_rsgn = r_rneg ? -w_rmag : w_rmag;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = r_state == S_MUL || r_state == S_DIV || r_state == S_DFIX;
        done   = r_state == S_DONE;
        case (r_state)
            S_IDLE: if (start) w_next = op == OP_MUL ? S_MUL : op == OP_DIV ? S_DIV : S_DONE;
            S_MUL:  if (r_cnt == SHW'(WIDTH / 2 - 1)) w_next = S_DONE;
            S_DIV:  if (r_cnt == SHW'(WIDTH - 1)) w_next = S_DFIX;
            S_DFIX: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_mq        <= '0;
            r_acc       <= '0;
            r_q         <= 1'b0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dz        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_a         <= a;
            r_mq        <= b;
            r_acc       <= '0;
            r_q         <= 1'b0;
            r_dvs       <= w_abs_b;
            r_quo       <= w_abs_a;
            r_rem       <= '0;
            r_qneg      <= a[WIDTH-1] ^ b[WIDTH-1];
            r_rneg      <= a[WIDTH-1];
            r_dz        <= b == '0;
            div_by_zero <= 1'b0;
            if (w_single)
                result <= {{WIDTH{1'b0}}, w_lo};
        end else if (r_state == S_MUL) begin
            r_cnt <= r_cnt + SHW'(1);
            r_acc <= w_acc_n;
            r_mq  <= w_mq_n;
            r_q   <= r_mq[1];
            if (w_next == S_DONE)
                result <= {w_acc_n[WIDTH-1:0], w_mq_n};
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt + SHW'(1);
            r_rem <= w_rn;
            r_quo <= w_qn;
        end else if (r_state == S_DFIX) begin
            result      <= r_dz ? {r_a, {WIDTH{1'b1}}} : {w_rsgn, w_qs};
            div_by_zero <= r_dz;
        end
    end
endmodule
